// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use bubble insertion, feeding the ALU directly.
module id_ex_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  alu_src_i,
  input  logic [2:0]            alu_ctrl_i,
  input  logic                  reg_write_i,
  input  logic                  mem_write_i,
  input  logic                  branch_i,
  input  logic                  jump_i,
  input  logic [1:0]            result_src_i,
  input  logic [ADDR_WIDTH-1:0] exmem_rd_i,
  input  logic                  exmem_reg_write_i,
  input  logic [DATA_WIDTH-1:0] exmem_result_i,
  input  logic [ADDR_WIDTH-1:0] memwb_rd_i,
  input  logic                  memwb_reg_write_i,
  input  logic [DATA_WIDTH-1:0] memwb_result_i,
  output logic [DATA_WIDTH-1:0] ALUop1,
  output logic [DATA_WIDTH-1:0] ALUop2,
  output logic [2:0]            ALUctrl,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] imm_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  reg_write_o,
  output logic                  mem_write_o,
  output logic                  branch_o,
  output logic                  jump_o,
  output logic [1:0]            result_src_o,
  output logic                  valid_o,
  output logic                  load_use_o
);

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  alu_src;
    logic [2:0]            alu_ctrl;
    logic                  reg_write;
    logic                  mem_write;
    logic                  branch;
    logic                  jump;
    logic [1:0]            result_src;
  } stage_t;

  stage_t stage_q;
  stage_t stage_d;
  logic   bubble;
  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;

  // Decode-side payload as it would be captured.
  always_comb begin
    stage_d            = '0;
    stage_d.valid      = valid_i;
    stage_d.pc         = pc_i;
    stage_d.rs1_data   = rs1_data_i;
    stage_d.rs2_data   = rs2_data_i;
    stage_d.imm        = imm_i;
    stage_d.rs1_addr   = rs1_addr_i;
    stage_d.rs2_addr   = rs2_addr_i;
    stage_d.rd_addr    = rd_addr_i;
    stage_d.alu_src    = alu_src_i;
    stage_d.alu_ctrl   = alu_ctrl_i;
    stage_d.reg_write  = reg_write_i;
    stage_d.mem_write  = mem_write_i;
    stage_d.branch     = branch_i;
    stage_d.jump       = jump_i;
    stage_d.result_src = result_src_i;
  end

  // Load in EX whose destination is read by the instruction in decode.
  assign load_use_o = stage_q.valid
                    & (stage_q.result_src == RESULT_LOAD)
                    & (stage_q.rd_addr != '0)
                    & valid_i
                    & ((stage_q.rd_addr == rs1_addr_i) | (stage_q.rd_addr == rs2_addr_i));

  // An all-zero entry is the bubble: invalid, no side effects, rd = x0.
  assign bubble = load_use_o | ~valid_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else if (flush) begin
      stage_q <= '0;
    end else if (!stall) begin
      stage_q <= bubble ? '0 : stage_d;
    end
  end

  // Forwarding: EX/MEM is younger than MEM/WB, so it wins; x0 never forwards.
  always_comb begin
    fwd_a = stage_q.rs1_data;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == stage_q.rs1_addr)) begin
      fwd_a = exmem_result_i;
    end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == stage_q.rs1_addr)) begin
      fwd_a = memwb_result_i;
    end
  end

  always_comb begin
    fwd_b = stage_q.rs2_data;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == stage_q.rs2_addr)) begin
      fwd_b = exmem_result_i;
    end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == stage_q.rs2_addr)) begin
      fwd_b = memwb_result_i;
    end
  end

  assign ALUop1       = fwd_a;
  assign write_data_o = fwd_b;
  assign ALUop2       = stage_q.alu_src ? stage_q.imm : fwd_b;
  assign ALUctrl      = stage_q.alu_ctrl;
  assign pc_o         = stage_q.pc;
  assign imm_o        = stage_q.imm;
  assign rd_addr_o    = stage_q.rd_addr;
  assign reg_write_o  = stage_q.reg_write;
  assign mem_write_o  = stage_q.mem_write;
  assign branch_o     = stage_q.branch;
  assign jump_o       = stage_q.jump;
  assign result_src_o = stage_q.result_src;
  assign valid_o      = stage_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table through a scoreboard queue, then
// hand sequences for load-use, stall/flush and asynchronous reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, valid_i;
  logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic        alu_src_i;
  logic [2:0]  alu_ctrl_i;
  logic        reg_write_i, mem_write_i, branch_i, jump_i;
  logic [1:0]  result_src_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic        exmem_reg_write_i, memwb_reg_write_i;
  logic [31:0] exmem_result_i, memwb_result_i;
  logic [31:0] ALUop1, ALUop2, write_data_o, pc_o, imm_o;
  logic [2:0]  ALUctrl;
  logic [4:0]  rd_addr_o;
  logic        reg_write_o, mem_write_o, branch_o, jump_o, valid_o, load_use_o;
  logic [1:0]  result_src_o;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_i(valid_i),
    .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .alu_src_i(alu_src_i), .alu_ctrl_i(alu_ctrl_i),
    .reg_write_i(reg_write_i), .mem_write_i(mem_write_i), .branch_i(branch_i),
    .jump_i(jump_i), .result_src_i(result_src_i),
    .exmem_rd_i(exmem_rd_i), .exmem_reg_write_i(exmem_reg_write_i),
    .exmem_result_i(exmem_result_i), .memwb_rd_i(memwb_rd_i),
    .memwb_reg_write_i(memwb_reg_write_i), .memwb_result_i(memwb_result_i),
    .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl), .write_data_o(write_data_o),
    .pc_o(pc_o), .imm_o(imm_o), .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o),
    .mem_write_o(mem_write_o), .branch_o(branch_o), .jump_o(jump_o),
    .result_src_o(result_src_o), .valid_o(valid_o), .load_use_o(load_use_o)
  );

  always #5 clk = ~clk;

  // ctl bits: [3] reg_write, [2] mem_write, [1] branch, [0] jump
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        src;
    logic [2:0]  ctrl;
    logic [3:0]  ctl;
    logic [1:0]  rsrc;
    logic [4:0]  exrd;
    logic        exwe;
    logic [31:0] exres;
    logic [4:0]  wbrd;
    logic        wbwe;
    logic [31:0] wbres;
  } in_t;

  typedef struct packed {
    logic [31:0] op1, op2, wd;
    logic [2:0]  ctrl;
    logic        valid;
    logic [3:0]  ctl;
    logic [4:0]  rd;
    logic [1:0]  rsrc;
    logic [31:0] pc, imm;
  } exp_t;

  typedef struct packed {
    in_t  in;
    exp_t ex;
  } vec_t;

  function automatic in_t mk_in(input logic v, input logic [31:0] pc, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] imm,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic src, input logic [2:0] ctrl, input logic [3:0] ctl,
                                input logic [1:0] rsrc);
    in_t r;
    r = '0;
    r.valid = v; r.pc = pc; r.rs1d = a; r.rs2d = b; r.imm = imm;
    r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.src = src; r.ctrl = ctrl; r.ctl = ctl; r.rsrc = rsrc;
    return r;
  endfunction

  function automatic in_t fwd(input in_t i, input logic [4:0] exrd, input logic exwe,
                              input logic [31:0] exres, input logic [4:0] wbrd,
                              input logic wbwe, input logic [31:0] wbres);
    in_t r;
    r = i;
    r.exrd = exrd; r.exwe = exwe; r.exres = exres;
    r.wbrd = wbrd; r.wbwe = wbwe; r.wbres = wbres;
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] op1, input logic [31:0] op2,
                                  input logic [31:0] wd, input logic [2:0] ctrl, input logic v,
                                  input logic [3:0] ctl, input logic [4:0] rd,
                                  input logic [1:0] rsrc, input logic [31:0] pc,
                                  input logic [31:0] imm);
    exp_t r;
    r.op1 = op1; r.op2 = op2; r.wd = wd; r.ctrl = ctrl; r.valid = v; r.ctl = ctl;
    r.rd = rd; r.rsrc = rsrc; r.pc = pc; r.imm = imm;
    return r;
  endfunction

  task automatic drive(input in_t i);
    valid_i = i.valid; pc_i = i.pc; rs1_data_i = i.rs1d; rs2_data_i = i.rs2d; imm_i = i.imm;
    rs1_addr_i = i.rs1; rs2_addr_i = i.rs2; rd_addr_i = i.rd; alu_src_i = i.src;
    alu_ctrl_i = i.ctrl; {reg_write_i, mem_write_i, branch_i, jump_i} = i.ctl;
    result_src_i = i.rsrc;
    exmem_rd_i = i.exrd; exmem_reg_write_i = i.exwe; exmem_result_i = i.exres;
    memwb_rd_i = i.wbrd; memwb_reg_write_i = i.wbwe; memwb_result_i = i.wbres;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_exp(input int idx, input exp_t e);
    string p;
    p = $sformatf("vec%0d", idx);
    chk({p, ".ALUop1"},       ALUop1, e.op1);
    chk({p, ".ALUop2"},       ALUop2, e.op2);
    chk({p, ".write_data_o"}, write_data_o, e.wd);
    chk({p, ".ALUctrl"},      32'(ALUctrl), 32'(e.ctrl));
    chk({p, ".valid_o"},      32'(valid_o), 32'(e.valid));
    chk({p, ".ctl"},          32'({reg_write_o, mem_write_o, branch_o, jump_o}), 32'(e.ctl));
    chk({p, ".rd_addr_o"},    32'(rd_addr_o), 32'(e.rd));
    chk({p, ".result_src_o"}, 32'(result_src_o), 32'(e.rsrc));
    chk({p, ".pc_o"},         pc_o, e.pc);
    chk({p, ".imm_o"},        imm_o, e.imm);
    chk({p, ".load_use_o"},   32'(load_use_o), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit %0d ns", 100000);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[9];
    exp_t sb[$];
    exp_t e;
    in_t  ld, dep, st;

    tab[0].in = fwd(mk_in(1, 32'h100, 32'd7, 32'd3, 32'd0, 5'd1, 5'd2, 5'd4, 0, 3'b001, 4'b1000, 2'b00),
                    5'd0, 0, 32'd0, 5'd0, 0, 32'd0);
    tab[0].ex = mk_exp(32'd7, 32'd3, 32'd3, 3'b001, 1, 4'b1000, 5'd4, 2'b00, 32'h100, 32'd0);
    tab[1].in = fwd(mk_in(1, 32'h104, 32'hAAAA, 32'd6, 32'd0, 5'd5, 5'd6, 5'd7, 0, 3'b000, 4'b1000, 2'b00),
                    5'd5, 1, 32'h11, 5'd5, 1, 32'h22);
    tab[1].ex = mk_exp(32'h11, 32'd6, 32'd6, 3'b000, 1, 4'b1000, 5'd7, 2'b00, 32'h104, 32'd0);
    tab[2].in = fwd(mk_in(1, 32'h108, 32'hAAAA, 32'd6, 32'd0, 5'd5, 5'd6, 5'd7, 0, 3'b000, 4'b1000, 2'b00),
                    5'd5, 0, 32'h11, 5'd5, 1, 32'h22);
    tab[2].ex = mk_exp(32'h22, 32'd6, 32'd6, 3'b000, 1, 4'b1000, 5'd7, 2'b00, 32'h108, 32'd0);
    tab[3].in = fwd(mk_in(1, 32'h10C, 32'hAAAA, 32'd6, 32'd0, 5'd5, 5'd6, 5'd7, 0, 3'b000, 4'b1000, 2'b00),
                    5'd0, 1, 32'h11, 5'd0, 1, 32'h22);
    tab[3].ex = mk_exp(32'hAAAA, 32'd6, 32'd6, 3'b000, 1, 4'b1000, 5'd7, 2'b00, 32'h10C, 32'd0);
    tab[4].in = fwd(mk_in(1, 32'h110, 32'h55, 32'h66, 32'd0, 5'd0, 5'd0, 5'd8, 0, 3'b100, 4'b1000, 2'b00),
                    5'd0, 1, 32'h11, 5'd0, 1, 32'h22);
    tab[4].ex = mk_exp(32'h55, 32'h66, 32'h66, 3'b100, 1, 4'b1000, 5'd8, 2'b00, 32'h110, 32'd0);
    tab[5].in = fwd(mk_in(1, 32'h114, 32'd3, 32'd1, 32'hFFFFFFFC, 5'd9, 5'd7, 5'd0, 1, 3'b000, 4'b0100, 2'b00),
                    5'd0, 0, 32'd0, 5'd7, 1, 32'h99);
    tab[5].ex = mk_exp(32'd3, 32'hFFFFFFFC, 32'h99, 3'b000, 1, 4'b0100, 5'd0, 2'b00, 32'h114, 32'hFFFFFFFC);
    tab[6].in = fwd(mk_in(0, 32'h118, 32'hDEAD, 32'hBEEF, 32'h44, 5'd3, 5'd3, 5'd3, 1, 3'b111, 4'b1111, 2'b01),
                    5'd3, 1, 32'h77, 5'd3, 1, 32'h88);
    tab[6].ex = mk_exp(32'd0, 32'd0, 32'd0, 3'b000, 0, 4'b0000, 5'd0, 2'b00, 32'd0, 32'd0);
    tab[7].in = fwd(mk_in(1, 32'h11C, 32'd1, 32'd2, 32'd8, 5'd2, 5'd2, 5'd1, 0, 3'b111, 4'b0011, 2'b10),
                    5'd2, 1, 32'h5A5A, 5'd2, 1, 32'd1);
    tab[7].ex = mk_exp(32'h5A5A, 32'h5A5A, 32'h5A5A, 3'b111, 1, 4'b0011, 5'd1, 2'b10, 32'h11C, 32'd8);
    tab[8].in = fwd(mk_in(1, 32'h120, 32'd1, 32'd2, 32'd0, 5'd9, 5'd10, 5'd11, 0, 3'b101, 4'b1000, 2'b00),
                    5'd9, 1, 32'h1234, 5'd10, 1, 32'h5678);
    tab[8].ex = mk_exp(32'h1234, 32'h5678, 32'h5678, 3'b101, 1, 4'b1000, 5'd11, 2'b00, 32'h120, 32'd0);

    // Reset state
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(tab[0].in);
    @(negedge clk); @(negedge clk);
    chk("reset.valid_o", 32'(valid_o), 32'(0));
    chk("reset.ALUop1", ALUop1, 32'd0);
    chk("reset.ALUctrl", 32'(ALUctrl), 32'(0));
    chk("reset.reg_write_o", 32'(reg_write_o), 32'(0));
    rst = 1'b0;

    // Table vectors through the scoreboard
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(tab[i].in);
      sb.push_back(tab[i].ex);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("scoreboard.empty", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        chk_exp(i, e);
      end
    end

    // Load-use: one bubble, then MEM/WB forwarding resolves it
    @(negedge clk);
    ld = fwd(mk_in(1, 32'h200, 32'h10, 32'd0, 32'd0, 5'd1, 5'd2, 5'd3, 1, 3'b000, 4'b1000, 2'b01),
             5'd0, 0, 32'd0, 5'd0, 0, 32'd0);
    drive(ld);
    @(negedge clk);
    dep = fwd(mk_in(1, 32'h204, 32'h40, 32'h30, 32'd0, 5'd4, 5'd3, 5'd5, 0, 3'b000, 4'b1000, 2'b00),
              5'd0, 0, 32'd0, 5'd0, 0, 32'd0);
    drive(dep);
    #1;
    chk("lu.load_use_o", 32'(load_use_o), 32'(1));
    @(posedge clk); #1;
    chk("lu.bubble.valid_o", 32'(valid_o), 32'(0));
    chk("lu.bubble.ctl", 32'({reg_write_o, mem_write_o, branch_o, jump_o}), 32'(0));
    chk("lu.bubble.ALUctrl", 32'(ALUctrl), 32'(0));
    chk("lu.bubble.load_use_o", 32'(load_use_o), 32'(0));
    @(negedge clk);
    drive(fwd(dep, 5'd0, 0, 32'd0, 5'd3, 1, 32'hBEEF));
    @(posedge clk); #1;
    chk("lu.enter.valid_o", 32'(valid_o), 32'(1));
    chk("lu.enter.rd_addr_o", 32'(rd_addr_o), 32'(5));
    chk("lu.enter.ALUop1", ALUop1, 32'h40);
    chk("lu.enter.ALUop2", ALUop2, 32'hBEEF);
    chk("lu.enter.write_data_o", write_data_o, 32'hBEEF);
    chk("lu.enter.load_use_o", 32'(load_use_o), 32'(0));

    // Stall holds for 3 cycles; forwarding stays live; flush beats stall
    @(negedge clk);
    st = fwd(mk_in(1, 32'h300, 32'h123, 32'd0, 32'd0, 5'd11, 5'd12, 5'd8, 0, 3'b110, 4'b1000, 2'b00),
             5'd0, 0, 32'd0, 5'd0, 0, 32'd0);
    drive(st);
    @(negedge clk);
    stall = 1'b1;
    drive(fwd(mk_in(1, 32'h304, 32'h999, 32'd1, 32'd0, 5'd13, 5'd14, 5'd9, 0, 3'b001, 4'b0010, 2'b10),
              5'd0, 0, 32'd0, 5'd0, 0, 32'd0));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d.ALUctrl", c), 32'(ALUctrl), 32'(3'b110));
      chk($sformatf("stall%0d.rd_addr_o", c), 32'(rd_addr_o), 32'(8));
      chk($sformatf("stall%0d.ALUop1", c), ALUop1, 32'h123);
      chk($sformatf("stall%0d.pc_o", c), pc_o, 32'h300);
    end
    @(negedge clk);
    exmem_rd_i = 5'd11; exmem_reg_write_i = 1'b1; exmem_result_i = 32'h321;
    #1;
    chk("stall.fwd.ALUop1", ALUop1, 32'h321);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush.valid_o", 32'(valid_o), 32'(0));
    chk("flush.rd_addr_o", 32'(rd_addr_o), 32'(0));
    chk("flush.ALUctrl", 32'(ALUctrl), 32'(0));
    chk("flush.ALUop1", ALUop1, 32'd0);
    @(negedge clk);
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset between clock edges
    drive(fwd(mk_in(1, 32'h400, 32'd5, 32'd0, 32'd0, 5'd1, 5'd0, 5'd2, 0, 3'b000, 4'b1000, 2'b00),
              5'd0, 0, 32'd0, 5'd0, 0, 32'd0));
    @(posedge clk); #1;
    chk("arst.pre.ALUop1", ALUop1, 32'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.valid_o", 32'(valid_o), 32'(0));
    chk("arst.ALUop1", ALUop1, 32'd0);
    chk("arst.reg_write_o", 32'(reg_write_o), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register plus operand-forwarding muxes, sitting directly upstream of the ALU in the pipelined RV32I core. It captures decoded operands and control each cycle. It drives ALUop1/ALUop2/ALUctrl straight into the ALU, resolving RAW hazards from the EX/MEM and MEM/WB stages. It also detects load-use hazards and inserts the required bubble.

Parameters:
DATA_WIDTH, 32, operand/result width
ADDR_WIDTH, 5, register-file address width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
stall  in  1  hold all registered fields
flush  in  1  replace next registered content with bubble
valid_i  in  1  decode stage holds a real instruction
pc_i  in  DATA_WIDTH  instruction PC
rs1_data_i, rs2_data_i  in  DATA_WIDTH  register-file read data
imm_i  in  DATA_WIDTH  sign-extended immediate
rs1_addr_i, rs2_addr_i, rd_addr_i  in  ADDR_WIDTH  register addresses
alu_src_i  in  1  1 = operand B from immediate
alu_ctrl_i  in  3  ALU op code (000 add, 001 sub, 111 and, 110 or, 100 xor, 010 sll, 101 srl)
reg_write_i, mem_write_i, branch_i, jump_i  in  1  control flags
result_src_i  in  2  00 ALU, 01 load, 10 PC+4
exmem_rd_i  in  ADDR_WIDTH  EX/MEM destination
exmem_reg_write_i  in  1  EX/MEM writes register
exmem_result_i  in  DATA_WIDTH  EX/MEM ALU result
memwb_rd_i  in  ADDR_WIDTH  MEM/WB destination
memwb_reg_write_i  in  1  MEM/WB writes register
memwb_result_i  in  DATA_WIDTH  MEM/WB writeback value
ALUop1, ALUop2  out  DATA_WIDTH  forwarded ALU operands
ALUctrl  out  3  registered ALU op
write_data_o  out  DATA_WIDTH  forwarded rs2 (store data)
pc_o, imm_o  out  DATA_WIDTH  registered PC / immediate
rd_addr_o  out  ADDR_WIDTH  registered destination
reg_write_o, mem_write_o, branch_o, jump_o  out  1  registered control, forced 0 in bubbles
result_src_o  out  2  registered result select
valid_o  out  1  stage holds a real instruction
load_use_o  out  1  combinational load-use hazard request to IF/ID

Behaviour:
- Reset: async on rst high. All registered fields go to 0, so valid_o=0, ALUctrl=000, all control 0. ALUop1/ALUop2/write_data_o then read 0, because x0 is never forwarded.
- Update priority on each rising clk edge: rst > flush > stall > load_use bubble > load.
- flush=1: load a bubble (valid=0, reg_write/mem_write/branch/jump=0, rd=0, ALUctrl=000, data fields 0). Flush wins over simultaneous stall.
- stall=1 with flush=0: all registers hold. Forwarding muxes stay live, so operands track the changing EX/MEM and MEM/WB values.
- load_use_o = valid_o & (result_src_o==01) & (rd_addr_o!=0) & valid_i & (rd_addr_o==rs1_addr_i | rd_addr_o==rs2_addr_i).
- When load_use_o=1 and stall=0: the stage loads a bubble. Upstream must hold IF/ID for that cycle. Exactly one bubble per load-use; the next cycle it is resolved by MEM/WB forwarding.
- valid_i=0: registered as a bubble.
- Forward A (1 cycle after capture, combinational from registers):
  - If exmem_reg_write_i & exmem_rd_i!=0 & exmem_rd_i==rs1 reg, use exmem_result_i.
  - Else if the same test holds on MEM/WB, use memwb_result_i.
  - Else use registered rs1_data.
  - EX/MEM has priority over MEM/WB.
- Forward B: same rule on rs2, producing write_data_o. ALUop2 = registered alu_src ? registered imm : write_data_o.
- Bubble entries never match for forwarding because rd=0. Register x0 is never forwarded, even if a producer claims rd=0.
- Latency: decode inputs reach ALU ports 1 cycle after capture. No combinational path from decode inputs to ALU ports, except via load_use_o.

Test Plan:
- Reset mid-operation: load add with rs1_data=5, then assert rst between clock edges -> valid_o=0, ALUop1=0, reg_write_o=0 immediately, without waiting for a clock edge.
- Plain capture: rs1_data=7, rs2_data=3, alu_ctrl=001, alu_src=0 -> next cycle ALUop1=7, ALUop2=3, ALUctrl=001, valid_o=1.
- Forward priority: rs1=x5, exmem_rd=5/result=0x11, memwb_rd=5/result=0x22 -> ALUop1=0x11. Drop exmem_reg_write -> 0x22. Set both rd to 0 -> raw value.
- Immediate vs store data: alu_src=1, imm=-4, rs2 forwarded from MEM/WB=0x99 -> ALUop2=0xFFFFFFFC, write_data_o=0x99.
- Load-use: EX holds load rd=x3, decode rs2=x3 -> load_use_o=1, next cycle valid_o=0 with all control 0. The following cycle the instruction enters with no second bubble.
- Stall/flush: stall=1 for 3 cycles -> fields unchanged. stall=1 and flush=1 together -> bubble loaded.
